// File: rtl/axo_base_pkg.sv
// Shared RV32I encodings for the Axolotl32 core: opcodes, SYSTEM encodings, decode records.
package axo_base;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic        valid;
        logic        will_read;
        logic        will_write;
        logic        uses_alu;
        logic        does_flowctl;
        logic        is_ecall;
        logic        is_ebreak;
        logic        is_32bit;
        logic        is_imm;
        logic [31:0] imm;
        logic        rd_we;
        logic        rs1_re;
        logic        rs2_re;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } dec_out_t;

endpackage

// File: rtl/axo32_decoder_if.sv
// Decoder bus: instruction word in, registered decode results out.
interface axo32_decoder_if;

    logic [31:0] inst;
    logic        op_valid;
    logic        op_will_read;
    logic        op_will_write;
    logic        op_uses_alu;
    logic        op_does_flowctl;
    logic        op_is_ecall;
    logic        op_is_ebreak;
    logic        op_32bit;
    logic        op_is_imm;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1_re;
    logic        rs2_re;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    modport master (
        output inst,
        input  op_valid, op_will_read, op_will_write, op_uses_alu, op_does_flowctl,
        input  op_is_ecall, op_is_ebreak, op_32bit, op_is_imm, imm,
        input  rd_we, rs1_re, rs2_re, rd, rs1, rs2
    );

    modport slave (
        input  inst,
        output op_valid, op_will_read, op_will_write, op_uses_alu, op_does_flowctl,
        output op_is_ecall, op_is_ebreak, op_32bit, op_is_imm, imm,
        output rd_we, rs1_re, rs2_re, rd, rs1, rs2
    );

endinterface

// File: rtl/axo32_decoder_imm_decode.sv
// Purpose: pick the immediate format from the opcode and build the sign-extended immediate.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module axo32_imm_decode
    import axo_base::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output imm_fmt_t    fmt
);

    logic [2:0] funct3;
    assign funct3 = inst[14:12];

    always_comb begin
        fmt = IMM_NONE;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_OP_IMM:         fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_STORE:          fmt = IMM_S;
            OPC_BRANCH:         fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: fmt = IMM_U;
            OPC_JAL:            fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
            IMM_SHAMT: imm = {27'b0, inst[24:20]};
            IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     imm = {inst[31:12], 12'b0};
            IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/axo32_decoder.sv
// Purpose: classify an RV32I instruction word and extract immediate/register operands.
// Latency: one cycle; outputs reflect the inst sampled at the previous rising edge.
// Backpressure: none; decodes every cycle unconditionally.
module axo32_decoder
    import axo_base::*;
(
    input  logic            clk,
    input  logic            rst,
    axo32_decoder_if.slave  dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = dec.inst[6:0];
    assign funct3 = dec.inst[14:12];
    assign funct7 = dec.inst[31:25];

    logic [31:0] imm_raw;
    imm_fmt_t    imm_fmt;

    axo32_imm_decode u_imm (
        .inst (dec.inst),
        .imm  (imm_raw),
        .fmt  (imm_fmt)
    );

    logic legal;
    logic c_read, c_write, c_alu, c_flow, c_ecall, c_ebreak;
    logic c_rd_we, c_rs1_re, c_rs2_re;

    always_comb begin
        legal    = 1'b0;
        c_read   = 1'b0;
        c_write  = 1'b0;
        c_alu    = 1'b0;
        c_flow   = 1'b0;
        c_ecall  = 1'b0;
        c_ebreak = 1'b0;
        c_rd_we  = 1'b0;
        c_rs1_re = 1'b0;
        c_rs2_re = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal   = 1'b1;
                c_alu   = 1'b1;
                c_rd_we = 1'b1;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                c_flow  = 1'b1;
                c_rd_we = 1'b1;
            end
            OPC_JALR: begin
                legal    = (funct3 == 3'b000);
                c_flow   = 1'b1;
                c_rd_we  = 1'b1;
                c_rs1_re = 1'b1;
            end
            OPC_BRANCH: begin
                legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                c_flow   = 1'b1;
                c_rs1_re = 1'b1;
                c_rs2_re = 1'b1;
            end
            OPC_LOAD: begin
                legal    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                c_read   = 1'b1;
                c_rd_we  = 1'b1;
                c_rs1_re = 1'b1;
            end
            OPC_STORE: begin
                legal    = funct3 inside {3'b000, 3'b001, 3'b010};
                c_write  = 1'b1;
                c_rs1_re = 1'b1;
                c_rs2_re = 1'b1;
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse the upper bits as funct7; only SRAI may set bit 30.
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
                c_alu    = 1'b1;
                c_rd_we  = 1'b1;
                c_rs1_re = 1'b1;
            end
            OPC_OP: begin
                legal    = (funct7 == F7_BASE) ||
                           ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
                c_alu    = 1'b1;
                c_rd_we  = 1'b1;
                c_rs1_re = 1'b1;
                c_rs2_re = 1'b1;
            end
            OPC_MISC_MEM: begin
                legal = (funct3 == 3'b000);
            end
            OPC_SYSTEM: begin
                c_ecall  = (dec.inst == INST_ECALL);
                c_ebreak = (dec.inst == INST_EBREAK);
                legal    = c_ecall || c_ebreak;
            end
            default: legal = 1'b0;
        endcase
    end

    dec_out_t d_next;
    dec_out_t d_q;

    always_comb begin
        d_next          = '0;
        // Reported even for illegal words so the pipeline can flag RV64-only encodings.
        d_next.is_32bit = (opcode == OPC_OP_IMM_32) || (opcode == OPC_OP_32);
        if (legal) begin
            d_next.valid        = 1'b1;
            d_next.will_read    = c_read;
            d_next.will_write   = c_write;
            d_next.uses_alu     = c_alu;
            d_next.does_flowctl = c_flow;
            d_next.is_ecall     = c_ecall;
            d_next.is_ebreak    = c_ebreak;
            d_next.is_imm       = (imm_fmt != IMM_NONE);
            d_next.imm          = imm_raw;
            d_next.rd_we        = c_rd_we;
            d_next.rs1_re       = c_rs1_re;
            d_next.rs2_re       = c_rs2_re;
            d_next.rd           = c_rd_we  ? dec.inst[11:7]  : 5'd0;
            d_next.rs1          = c_rs1_re ? dec.inst[19:15] : 5'd0;
            d_next.rs2          = c_rs2_re ? dec.inst[24:20] : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_next;
        end
    end

    assign dec.op_valid        = d_q.valid;
    assign dec.op_will_read    = d_q.will_read;
    assign dec.op_will_write   = d_q.will_write;
    assign dec.op_uses_alu     = d_q.uses_alu;
    assign dec.op_does_flowctl = d_q.does_flowctl;
    assign dec.op_is_ecall     = d_q.is_ecall;
    assign dec.op_is_ebreak    = d_q.is_ebreak;
    assign dec.op_32bit        = d_q.is_32bit;
    assign dec.op_is_imm       = d_q.is_imm;
    assign dec.imm             = d_q.imm;
    assign dec.rd_we           = d_q.rd_we;
    assign dec.rs1_re          = d_q.rs1_re;
    assign dec.rs2_re          = d_q.rs2_re;
    assign dec.rd              = d_q.rd;
    assign dec.rs1             = d_q.rs1;
    assign dec.rs2             = d_q.rs2;

endmodule

// File: tb/tb_axo32_decoder.sv
// Bench for axo32_decoder: directed plan vectors plus randomized words against a table-driven model.
module tb_axo32_decoder;

    typedef struct packed {
        logic        valid;
        logic        rd_mem;
        logic        wr_mem;
        logic        alu;
        logic        flow;
        logic        ecall;
        logic        ebreak;
        logic        w32;
        logic        is_imm;
        logic [31:0] imm;
        logic        rd_we;
        logic        rs1_re;
        logic        rs2_re;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    axo32_decoder_if dif ();

    axo32_decoder dut (
        .clk (clk),
        .rst (rst),
        .dec (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    // Reference: decode by RISC-V opcode table using shifts/masks on the raw word.
    function automatic res_t model(input logic [31:0] i);
        res_t r;
        int   op, f3, f7;
        bit   ok;
        r  = '0;
        op = int'(i & 32'h7f);
        f3 = int'((i >> 12) & 32'h7);
        f7 = int'(i >> 25);
        ok = 1'b0;
        case (op)
            'h37, 'h17: begin ok = 1; r.alu = 1; r.rd_we = 1; r.is_imm = 1; r.imm = i & 32'hFFFFF000; end
            'h6f: begin
                ok = 1; r.flow = 1; r.rd_we = 1; r.is_imm = 1;
                r.imm = sext((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) |
                             (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21);
            end
            'h67: begin ok = (f3 == 0); r.flow = 1; r.rd_we = 1; r.rs1_re = 1; r.is_imm = 1; r.imm = sext(i >> 20, 12); end
            'h63: begin
                ok = (f3 != 2 && f3 != 3); r.flow = 1; r.rs1_re = 1; r.rs2_re = 1; r.is_imm = 1;
                r.imm = sext((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                             (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13);
            end
            'h03: begin
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                r.rd_mem = 1; r.rd_we = 1; r.rs1_re = 1; r.is_imm = 1; r.imm = sext(i >> 20, 12);
            end
            'h23: begin
                ok = (f3 <= 2); r.wr_mem = 1; r.rs1_re = 1; r.rs2_re = 1; r.is_imm = 1;
                r.imm = sext(((i >> 25) << 5) | ((i >> 7) & 31), 12);
            end
            'h13: begin
                r.alu = 1; r.rd_we = 1; r.rs1_re = 1; r.is_imm = 1;
                if (f3 == 1)      begin ok = (f7 == 0);               r.imm = (i >> 20) & 31; end
                else if (f3 == 5) begin ok = (f7 == 0 || f7 == 'h20); r.imm = (i >> 20) & 31; end
                else              begin ok = 1;                       r.imm = sext(i >> 20, 12); end
            end
            'h33: begin
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                r.alu = 1; r.rd_we = 1; r.rs1_re = 1; r.rs2_re = 1;
            end
            'h0f: ok = (f3 == 0);
            'h73: begin
                r.ecall  = (i == 32'h00000073);
                r.ebreak = (i == 32'h00100073);
                ok = r.ecall || r.ebreak;
            end
            default: ok = 0;
        endcase
        if (!ok) r = '0;
        r.valid = ok;
        if (r.rd_we)  r.rd  = 5'((i >> 7) & 31);
        if (r.rs1_re) r.rs1 = 5'((i >> 15) & 31);
        if (r.rs2_re) r.rs2 = 5'((i >> 20) & 31);
        r.w32 = (op == 'h1b || op == 'h3b);
        return r;
    endfunction

    function automatic res_t observe();
        res_t o;
        o.valid  = dif.op_valid;        o.rd_mem = dif.op_will_read;
        o.wr_mem = dif.op_will_write;   o.alu    = dif.op_uses_alu;
        o.flow   = dif.op_does_flowctl; o.ecall  = dif.op_is_ecall;
        o.ebreak = dif.op_is_ebreak;    o.w32    = dif.op_32bit;
        o.is_imm = dif.op_is_imm;       o.imm    = dif.imm;
        o.rd_we  = dif.rd_we;           o.rs1_re = dif.rs1_re;
        o.rs2_re = dif.rs2_re;          o.rd     = dif.rd;
        o.rs1    = dif.rs1;             o.rs2    = dif.rs2;
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [15];
        logic [31:0] w;
        int k;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                7'h33, 7'h0f, 7'h73, 7'h1b, 7'h3b, 7'h13, 7'h33};
        w = $urandom;
        k = $urandom_range(0, 19);
        if (k < 15) w[6:0] = ops[k];
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if (w[6:0] == 7'h73 && $urandom_range(0, 2) != 0)
            w = $urandom_range(0, 1) ? 32'h00000073 : 32'h00100073;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t got;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dif.inst = (k == 0) ? 32'h00200193 : rand_inst();
            tick();
            got = observe();
            n_vec++;
            if (got !== res_t'(0)) begin
                n_err++;
                $display("FAIL reset inst=%08h got=%h want=0", dif.inst, got);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] plan [9];
        res_t got, want;
        plan = '{32'h00200193, 32'h00209093, 32'h40209093, 32'h00000497, 32'hff84a083,
                 32'h00000000, 32'h00000073, 32'h00100073, 32'h0000000f};
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            dif.inst = plan[k];
            want = model(plan[k]);
            tick();
            got = observe();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL directed inst=%08h got=%h want=%h", plan[k], got, want);
            end
            case (k)
                0: begin
                    n_vec++;
                    if (got.imm !== 32'h2 || got.rd !== 5'd3 || got.valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL addi_fields imm=%08h rd=%0d valid=%b want 00000002/3/1", got.imm, got.rd, got.valid);
                    end
                end
                2: begin
                    n_vec++;
                    if (got.valid !== 1'b0 || got.alu !== 1'b0 || got.rd_we !== 1'b0) begin
                        n_err++;
                        $display("FAIL slli_bad_f7 valid=%b alu=%b rd_we=%b want 0/0/0", got.valid, got.alu, got.rd_we);
                    end
                end
                4: begin
                    n_vec++;
                    if (got.imm !== 32'hFFFFFFF8 || got.rd_mem !== 1'b1 || got.rs1 !== 5'd9) begin
                        n_err++;
                        $display("FAIL lw_fields imm=%08h read=%b rs1=%0d want fffffff8/1/9", got.imm, got.rd_mem, got.rs1);
                    end
                end
                6: begin
                    n_vec++;
                    if (got.ecall !== 1'b1 || got.ebreak !== 1'b0) begin
                        n_err++;
                        $display("FAIL ecall_flag ecall=%b ebreak=%b want 1/0", got.ecall, got.ebreak);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_rv64_words();
        res_t got;
        logic [31:0] w [2];
        w = '{32'h0010809b, 32'h002081bb};
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dif.inst = w[k];
            tick();
            got = observe();
            n_vec++;
            if (got.w32 !== 1'b1 || got.valid !== 1'b0 || got.imm !== 32'h0 || got.rd_we !== 1'b0) begin
                n_err++;
                $display("FAIL op32 inst=%08h w32=%b valid=%b imm=%08h rd_we=%b want 1/0/0/0",
                         w[k], got.w32, got.valid, got.imm, got.rd_we);
            end
        end
    endtask

    task automatic test_random();
        res_t got, want;
        logic [31:0] w;
        rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            w = rand_inst();
            dif.inst = w;
            want = model(w);
            tick();
            got = observe();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random inst=%08h got=%h want=%h", w, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        res_t got, want;
        logic [31:0] a, b;
        for (int k = 0; k < 20; k++) begin
            a = rand_inst();
            b = rand_inst();
            rst = 1'b1;
            dif.inst = a;
            tick();
            got = observe();
            n_vec++;
            if (got !== res_t'(0)) begin
                n_err++;
                $display("FAIL mid_reset inst=%08h got=%h want=0", a, got);
            end
            rst = 1'b0;
            dif.inst = b;
            want = model(b);
            tick();
            got = observe();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL post_reset inst=%08h got=%h want=%h", b, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, want;
        logic [31:0] w;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            w = k[0] ? 32'h00000000 : rand_inst();
            dif.inst = w;
            want = model(w);
            tick();
            got = observe();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL back_to_back inst=%08h got=%h want=%h", w, got, want);
            end
        end
    endtask

    initial begin
        dif.inst = 32'h0;
        test_reset();
        test_directed();
        test_rv64_words();
        test_random();
        test_reset_mid_stream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
